// File: rtl/decode_pkg.sv
// Shared decode definitions: microcode bit indices, ALU/branch enums,
// RV32I opcodes, fill/run/halt state codes and small decode helpers.
package decode_pkg;

    localparam int MC_USE_RS1     = 0;
    localparam int MC_USE_RS2     = 1;
    localparam int MC_ALU_A_RS1   = 2;
    localparam int MC_ALU_A_PC    = 3;
    localparam int MC_JUMP        = 4;
    localparam int MC_BRANCH      = 5;
    localparam int MC_ALU_B_RS2   = 6;
    localparam int MC_ALU_B_IMM_I = 7;
    localparam int MC_ALU_B_IMM_S = 8;
    localparam int MC_IMM_PCREL   = 9;
    localparam int MC_ALU_B_SHAMT = 10;
    localparam int MC_MEM_WRITE   = 11;
    localparam int MC_MEM_ACCESS  = 12;
    localparam int MC_STORE_DATA  = 13;
    localparam int MC_CTRL_FLOW   = 14;
    localparam int MC_MEM_ADDR    = 15;
    localparam int MC_REG_WRITE   = 16;
    localparam int MC_WB_IMM      = 17;
    localparam int MC_WB_ALU      = 18;
    localparam int MC_WB_PC4      = 19;
    localparam int MC_WB_MEM      = 20;
    localparam int MC_SIZE_B      = 21;
    localparam int MC_SIZE_H      = 22;
    localparam int MC_SEXT_B      = 23;
    localparam int MC_SEXT_H      = 24;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NONE   = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_LTU    = 3'd5,
        COND_GEU    = 3'd6,
        COND_ALWAYS = 3'd7
    } br_cond_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // alt is inst[30]; SUB is only meaningful for register-register ops
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt,
                                                input logic       allow_sub);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] mc_pack(input logic [24:0] flags,
                                            input alu_op_e     alu,
                                            input br_cond_e    cond);
        return {cond, alu, flags};
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: instruction word -> {microcode, illegal}.
// Unsupported encodings and FENCE/SYSTEM decode to an all-zero bubble.
module rv32i_decoder
    import decode_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] microcode_o,
    output logic        illegal_o
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    logic        alt_s;
    logic [24:0] flags_s;
    alu_op_e     alu_s;
    br_cond_e    cond_s;
    logic        bad_s;
    logic        unused_bits_s;

    assign opcode_s      = inst_i[6:0];
    assign rd_s          = inst_i[11:7];
    assign funct3_s      = inst_i[14:12];
    assign alt_s         = inst_i[30];
    assign unused_bits_s = ^{inst_i[31], inst_i[29:15]};

    // Per-class control flags, ALU op and branch condition
    always_comb begin
        flags_s = 25'd0;
        alu_s   = ALU_ADD;
        cond_s  = COND_NONE;
        bad_s   = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                flags_s[MC_REG_WRITE] = 1'b1;
                flags_s[MC_WB_IMM]    = 1'b1;
            end
            OPC_AUIPC: begin
                flags_s[MC_ALU_A_PC]  = 1'b1;
                flags_s[MC_IMM_PCREL] = 1'b1;
                flags_s[MC_REG_WRITE] = 1'b1;
                flags_s[MC_WB_ALU]    = 1'b1;
            end
            OPC_JAL: begin
                flags_s[MC_JUMP]      = 1'b1;
                flags_s[MC_IMM_PCREL] = 1'b1;
                flags_s[MC_CTRL_FLOW] = 1'b1;
                flags_s[MC_REG_WRITE] = 1'b1;
                flags_s[MC_WB_PC4]    = 1'b1;
                cond_s                = COND_ALWAYS;
            end
            OPC_JALR: begin
                flags_s[MC_USE_RS1]     = 1'b1;
                flags_s[MC_ALU_A_RS1]   = 1'b1;
                flags_s[MC_ALU_B_IMM_I] = 1'b1;
                flags_s[MC_CTRL_FLOW]   = 1'b1;
                flags_s[MC_REG_WRITE]   = 1'b1;
                flags_s[MC_WB_PC4]      = 1'b1;
                cond_s                  = COND_ALWAYS;
            end
            OPC_BRANCH: begin
                flags_s[MC_USE_RS1]   = 1'b1;
                flags_s[MC_USE_RS2]   = 1'b1;
                flags_s[MC_BRANCH]    = 1'b1;
                flags_s[MC_IMM_PCREL] = 1'b1;
                flags_s[MC_CTRL_FLOW] = 1'b1;
                case (funct3_s)
                    3'b000:  cond_s = COND_EQ;
                    3'b001:  cond_s = COND_NE;
                    3'b100:  cond_s = COND_LT;
                    3'b101:  cond_s = COND_GE;
                    3'b110:  cond_s = COND_LTU;
                    3'b111:  cond_s = COND_GEU;
                    default: bad_s  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                flags_s[MC_USE_RS1]     = 1'b1;
                flags_s[MC_ALU_A_RS1]   = 1'b1;
                flags_s[MC_ALU_B_IMM_I] = 1'b1;
                flags_s[MC_MEM_ACCESS]  = 1'b1;
                flags_s[MC_MEM_ADDR]    = 1'b1;
                flags_s[MC_REG_WRITE]   = 1'b1;
                flags_s[MC_WB_MEM]      = 1'b1;
                case (funct3_s)
                    3'b000:  flags_s[MC_SEXT_B] = 1'b1;
                    3'b001:  flags_s[MC_SEXT_H] = 1'b1;
                    3'b010:  bad_s              = 1'b0;
                    3'b100:  flags_s[MC_SIZE_B] = 1'b1;
                    3'b101:  flags_s[MC_SIZE_H] = 1'b1;
                    default: bad_s              = 1'b1;
                endcase
            end
            OPC_STORE: begin
                flags_s[MC_USE_RS1]     = 1'b1;
                flags_s[MC_USE_RS2]     = 1'b1;
                flags_s[MC_ALU_A_RS1]   = 1'b1;
                flags_s[MC_ALU_B_IMM_S] = 1'b1;
                flags_s[MC_MEM_WRITE]   = 1'b1;
                flags_s[MC_MEM_ACCESS]  = 1'b1;
                flags_s[MC_STORE_DATA]  = 1'b1;
                flags_s[MC_MEM_ADDR]    = 1'b1;
                case (funct3_s)
                    3'b000:  flags_s[MC_SIZE_B] = 1'b1;
                    3'b001:  flags_s[MC_SIZE_H] = 1'b1;
                    3'b010:  bad_s              = 1'b0;
                    default: bad_s              = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                flags_s[MC_USE_RS1]   = 1'b1;
                flags_s[MC_ALU_A_RS1] = 1'b1;
                flags_s[MC_REG_WRITE] = 1'b1;
                flags_s[MC_WB_ALU]    = 1'b1;
                // shifts take a shamt operand instead of the sign-extended I-immediate
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    flags_s[MC_ALU_B_SHAMT] = 1'b1;
                end else begin
                    flags_s[MC_ALU_B_IMM_I] = 1'b1;
                end
                alu_s = alu_from_funct3(funct3_s, alt_s, 1'b0);
            end
            OPC_OP: begin
                flags_s[MC_USE_RS1]   = 1'b1;
                flags_s[MC_USE_RS2]   = 1'b1;
                flags_s[MC_ALU_A_RS1] = 1'b1;
                flags_s[MC_ALU_B_RS2] = 1'b1;
                flags_s[MC_REG_WRITE] = 1'b1;
                flags_s[MC_WB_ALU]    = 1'b1;
                alu_s = alu_from_funct3(funct3_s, alt_s, 1'b1);
            end
            OPC_FENCE, OPC_SYSTEM: begin
                bad_s = 1'b0;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
        // x0 destination must not look like a producer to the hazard logic
        flags_s[MC_REG_WRITE] = flags_s[MC_REG_WRITE] & (rd_s != 5'd0);
    end

    assign microcode_o = bad_s ? 32'd0 : mc_pack(flags_s, alu_s, cond_s);
    assign illegal_o   = bad_s;

endmodule

// File: rtl/inst_decode_unit.sv
// Fetch-side decode stage: drives imem, registers decoded microcode, and
// emits bubbles during refill. ILLEGAL_HALT_EN adds a sticky HALT on illegal.
module inst_decode_unit
    import decode_pkg::*;
#(
    parameter int RESET_FILL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] pc,
    input  logic        squash,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] microcode_s0,
    output logic [24:0] instruction_data_s0,
    output logic        illegal
);

    localparam int               CNT_W     = $clog2(RESET_FILL + 1);
    localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(RESET_FILL);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [31:0]      microcode_q, microcode_d;
    logic [24:0]      inst_data_q, inst_data_d;
    logic             illegal_q, illegal_d;
    logic [31:0]      dec_mc_s;
    logic             dec_ill_s;

    rv32i_decoder u_decoder (
        .inst_i      (imem_data),
        .microcode_o (dec_mc_s),
        .illegal_o   (dec_ill_s)
    );

    assign imem_addr = pc;

    // Next-state logic; every path not explicitly decoding yields a bubble
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        microcode_d = 32'd0;
        inst_data_d = 25'd0;
        illegal_d   = 1'b0;
        if (squash && (state_q != ST_HALT)) begin
            state_d    = ST_FILL;
            fill_cnt_d = FILL_LOAD;
        end else begin
            case (state_q)
                ST_FILL: begin
                    fill_cnt_d = fill_cnt_q - FILL_LAST;
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    microcode_d = dec_mc_s;
                    inst_data_d = (dec_mc_s == 32'd0) ? 25'd0 : imem_data[31:7];
                    illegal_d   = dec_ill_s;
`ifdef ILLEGAL_HALT_EN
                    if (dec_ill_s) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
`endif
                end
                ST_HALT: begin
`ifdef ILLEGAL_HALT_EN
                    illegal_d = 1'b1;
`else
                    state_d    = ST_FILL;
                    fill_cnt_d = FILL_LOAD;
`endif
                end
                default: begin
                    state_d    = ST_FILL;
                    fill_cnt_d = FILL_LOAD;
                end
            endcase
        end
    end

    // Stage-s0 registers and FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= FILL_LOAD;
            microcode_q <= 32'd0;
            inst_data_q <= 25'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            microcode_q <= microcode_d;
            inst_data_q <= inst_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign microcode_s0        = microcode_q;
    assign instruction_data_s0 = inst_data_q;
    assign illegal             = illegal_q;

endmodule

// File: doc/inst_decode_unit.md
Name: inst_decode_unit

Overview:
- Instruction-side counterpart of the pipeline control unit. Takes the fetch PC, drives the synchronous instruction memory, and decodes the returned RV32I word.
- Produces the registered stage-s0 microcode word and operand-field word that the control unit consumes.
- Emits all-zero bubbles during pipeline refill after reset and after a redirect squash.
- Total latency from pc to microcode_s0 is 2 cycles, aligned with the control unit's PC shadow chain.

Parameters:
- RESET_FILL, 2, number of bubble cycles emitted after reset or squash; must be ≥ imem read latency + 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  30  word-addressed fetch PC from control unit
- squash  in  1  taken-redirect indication (jump_if_branch & branch)
- imem_addr  out  30  instruction memory word address; combinationally equal to pc
- imem_data  in  32  instruction word, valid 1 cycle after imem_addr
- microcode_s0  out  32  registered control word, bit map per decode package
- instruction_data_s0  out  25  registered inst[31:7] (rd=[4:0], funct3=[7:5], rs1=[12:8], rs2=[17:13])
- illegal  out  1  registered; high for the cycle an unsupported opcode is decoded

Behaviour:
- Reset, asynchronous: microcode_s0=0, instruction_data_s0=0, illegal=0, fill_cnt=RESET_FILL, state=FILL.
- States:
  - FILL: outputs are bubbles; fill_cnt decrements each cycle; on the cycle fill_cnt is 1, state becomes RUN.
  - RUN: every cycle registers decode(imem_data) into microcode_s0 and imem_data[31:7] into instruction_data_s0.
- squash=1 at an edge, in any state: the registered output that edge is a bubble; fill_cnt reloads to RESET_FILL; state becomes FILL. squash takes priority over decode. squash during FILL restarts the count.
- A bubble is microcode_s0=0 and instruction_data_s0=0. Therefore illegal=0, no dependency checks, no writes.
- Alignment: pc applied in cycle t gives microcode_s0 at t+2.
- Decode per opcode (microcode bit numbers):
  - LUI: 16,17
  - AUIPC: 3,9,16,18; alu=ADD
  - JAL: 4,9,14,16,19; alu=ADD; cond=7
  - JALR: 0,2,7,14,16,19; alu=ADD; cond=7
  - BRANCH: 0,1,5,9,14; alu=ADD; cond from funct3: BEQ→1, BNE→2, BLT→3, BGE→4, BLTU→5, BGEU→6. funct3 010/011 is illegal.
  - LOAD: 0,2,7,12,15,16,20; alu=ADD; trunc: LB→23, LH→24, LBU→21, LHU→22, LW none. Other funct3 is illegal.
  - STORE: 0,1,2,8,11,12,13,15; alu=ADD; SB→21, SH→22, SW none. funct3 >2 is illegal.
  - OP-IMM: 0,2,16,18; bit 7 as operand B, except SLLI/SRLI/SRAI which use bit 10. alu from funct3, with inst[30] selecting SRAI.
  - OP: 0,1,2,6,16,18; alu from funct3 plus inst[30] (SUB, SRA).
  - FENCE, SYSTEM: bubble, not illegal.
  - Anything else: bubble, illegal=1.
- rd==0 on any writing class: bit 16 cleared, all other bits kept (prevents false data-dependency stalls).
- ALU op field [28:25]: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9.
- Branch-condition field [31:29]: as listed per class; 0 elsewhere.

Optional Feature:
- Macro: ILLEGAL_HALT_EN.
- Defined:
  - An illegal opcode decoded in RUN moves the block to state HALT.
  - HALT emits bubbles indefinitely and holds illegal=1 (sticky).
  - squash does not leave HALT; only rst does.
- Undefined:
  - No HALT state exists; illegal is a 1-cycle pulse and decoding continues.

Decomposition:
- Package decode_pkg holds:
  - microcode bit-index localparams (0..24)
  - ALU op and branch-cond enums
  - RV32I opcode constants
  - state enum (FILL/RUN/HALT)
- Sub-module: rv32i_decoder, purely combinational, mapping instruction word to {microcode, illegal}.
- inst_decode_unit owns the registers, the fill counter and the FSM.

Test Plan:
- Reset, pc stepping 0,1,2… with imem holding ADDI x1,x0,5 at word 0:
  - 2 cycles of microcode_s0=0, then microcode_s0 bits {0,2,7,16,18}, alu=0.
  - instruction_data_s0[4:0]=1.
- imem_data=0x00000013 (ADDI x0,x0,0) → bit 16 clear, illegal=0.
- BLTU x1,x2 → cond field=5, bits {0,1,5,9,14}.
- LHU → bits include 22 and 20, not 23/24.
- SB → bits 11,13,21.
- squash pulsed while streaming ADDs → next 2 outputs are 0, third is the decoded word.
- imem_data=0xFFFFFFFF:
  - Undefined: illegal high for one cycle, stream resumes.
  - ILLEGAL_HALT_EN: illegal stays 1 and bubbles persist through squash until rst.
- rst asserted mid-stream (asynchronously, between edges) → outputs zero immediately, 2 bubbles after release.
